// File: rtl/clk_period_meter.sv
// clk_period_meter
// Measures the period of a slow periodic input in system-clock cycles.
// Each rising edge of the input reports the cycles since the previous
// rising edge, with a one-cycle valid strobe. A lock flag is raised after
// LOCK_COUNT consecutive periods each stay within TOL of the period before
// it. A sticky timeout flag is raised when no edge arrives within TIMEOUT
// cycles.

module clk_period_meter #(
   parameter int WIDTH      = 16,
   parameter int TIMEOUT    = 65535,
   parameter int LOCK_COUNT = 4,
   parameter int TOL        = 0
) (
   input  logic             i_CLK,
   input  logic             i_RST,
   input  logic             i_EN,
   input  logic             i_SIG,
   output logic [WIDTH-1:0] o_PERIOD,
   output logic             o_VALID,
   output logic             o_LOCKED,
   output logic             o_TIMEOUT
);

   // Match counter must hold 0 .. LOCK_COUNT inclusive.
   localparam int MW = $clog2(LOCK_COUNT + 1);

   localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
   localparam logic [MW-1:0]    LOCK_C    = MW'(LOCK_COUNT);
   localparam logic [WIDTH:0]   TOL_C     = (WIDTH + 1)'(TOL);

   typedef enum logic {
      ST_IDLE,
      ST_MEASURE
   } state_e;

   // Input conditioning
   logic s1_q;
   logic s2_q;
   logic p_q;
   logic rise;

   // Measurement state
   state_e           state_q;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] period_q;
   logic             valid_q;
   logic             timeout_q;

   // Lock tracking
   logic [WIDTH-1:0] prev_q;
   logic             prev_valid_q;
   logic [MW-1:0]    match_q;
   logic             locked_q;

   // Next values of the lock tracking, used when a rising edge lands
   logic [WIDTH:0]   cnt_ext;
   logic [WIDTH:0]   prev_ext;
   logic [WIDTH:0]   diff_d;
   logic [MW-1:0]    match_d;
   logic             locked_d;

   // Two-flop synchronizer on the asynchronous input, followed by a history
   // flop so a rising edge is seen for exactly one cycle.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         p_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let s2_q sample the old s1_q, so
         // this chain acts as a shift register regardless of statement order.
         s1_q <= i_SIG;
         s2_q <= s1_q;
         p_q  <= s2_q;
      end
   end

   assign rise = s2_q & ~p_q;

   // Absolute difference to the previous period and the match count that
   // follows if the current count is reported now.
   always_comb begin
      // NOTE: every signal written here is assigned on all paths, starting
      // with a default, so no latch is inferred.
      cnt_ext  = {1'b0, count_q};
      prev_ext = {1'b0, prev_q};
      diff_d   = (cnt_ext >= prev_ext) ? (cnt_ext - prev_ext)
                                       : (prev_ext - cnt_ext);
      match_d  = '0;
      if (prev_valid_q && (diff_d <= TOL_C)) begin
         if (match_q == LOCK_C) begin
            match_d = LOCK_C;
         end else begin
            match_d = match_q + 1'b1;
         end
      end
      locked_d = (match_d == LOCK_C);
   end

   // Measurement FSM: counts cycles between rising edges, reports each
   // period, maintains lock and detects missing edges.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         period_q     <= '0;
         valid_q      <= 1'b0;
         timeout_q    <= 1'b0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         match_q      <= '0;
         locked_q     <= 1'b0;
      end else begin
         // Strobe is high only on the cycle after a reported edge.
         valid_q <= 1'b0;

         if (!i_EN) begin
            // Disabled: drop back to IDLE; last period and timeout hold.
            state_q  <= ST_IDLE;
            count_q  <= '0;
            match_q  <= '0;
            locked_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  count_q <= '0;
                  if (rise) begin
                     // First edge only starts the count; no period yet.
                     state_q      <= ST_MEASURE;
                     count_q      <= WIDTH'(1);
                     match_q      <= '0;
                     prev_valid_q <= 1'b0;
                  end
               end

               ST_MEASURE: begin
                  if (rise) begin
                     // Edge wins over a coincident timeout.
                     period_q     <= count_q;
                     valid_q      <= 1'b1;
                     count_q      <= WIDTH'(1);
                     match_q      <= match_d;
                     locked_q     <= locked_d;
                     prev_q       <= count_q;
                     prev_valid_q <= 1'b1;
                     timeout_q    <= 1'b0;
                  end else if (count_q == TIMEOUT_C) begin
                     // No edge within the window: give up and wait for a
                     // fresh start.
                     state_q      <= ST_IDLE;
                     count_q      <= '0;
                     timeout_q    <= 1'b1;
                     locked_q     <= 1'b0;
                     match_q      <= '0;
                     prev_valid_q <= 1'b0;
                  end else begin
                     count_q <= count_q + 1'b1;
                  end
               end

               default: begin
                  state_q <= ST_IDLE;
                  count_q <= '0;
               end
            endcase
         end
      end
   end

   assign o_PERIOD  = period_q;
   assign o_VALID   = valid_q;
   assign o_LOCKED  = locked_q;
   assign o_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter.
// Stimulus pushes the expected report of every input segment into a queue;
// an independent monitor pops an entry on each o_VALID and compares.

module tb_clk_period_meter;

   localparam int WIDTH      = 16;
   localparam int TIMEOUT    = 100;
   localparam int LOCK_COUNT = 4;
   localparam int TOL        = 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             sig;
   logic [WIDTH-1:0] period;
   logic             valid;
   logic             locked;
   logic             timeout;

   typedef struct {
      int period;
      bit locked;
      bit chk_gap;
   } exp_t;

   exp_t   exp_q[$];
   int     n_cmp = 0;
   int     n_bad = 0;
   longint cyc = 0;
   longint last_cyc = 0;

   clk_period_meter #(
      .WIDTH      (WIDTH),
      .TIMEOUT    (TIMEOUT),
      .LOCK_COUNT (LOCK_COUNT),
      .TOL        (TOL)
   ) dut (
      .i_CLK     (clk),
      .i_RST     (rst),
      .i_EN      (en),
      .i_SIG     (sig),
      .o_PERIOD  (period),
      .o_VALID   (valid),
      .o_LOCKED  (locked),
      .o_TIMEOUT (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // One input segment starting with a rising edge: hi cycles high, lo low.
   task automatic pulse(input int hi, input int lo);
      sig = 1'b1;
      repeat (hi) tick();
      sig = 1'b0;
      repeat (lo) tick();
   endtask

   // Segment whose length is reported at the following rising edge.
   task automatic seg(input int hi, input int lo, input bit lk, input bit gap);
      pulse(hi, lo);
      exp_q.push_back(exp_t'{period: hi + lo, locked: lk, chk_gap: gap});
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("period", longint'(period), e.period);
               check("locked_on_valid", longint'(locked), longint'(e.locked));
               if (e.chk_gap) check("strobe_gap", cyc - last_cyc, e.period);
            end
            last_cyc = cyc;
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      sig = 1'b0;
      tick();
      tick();

      // Reset values
      check("rst_period",  longint'(period),  0);
      check("rst_valid",   longint'(valid),   0);
      check("rst_locked",  longint'(locked),  0);
      check("rst_timeout", longint'(timeout), 0);
      rst = 1'b0;
      repeat (3) tick();

      // Steady lock: first edge silent, lock on the 5th report.
      for (int i = 1; i <= 7; i++) seg(10, 10, i >= 5, i >= 2);

      // Timeout: one more edge, then the input stays low.
      sig = 1'b1;
      repeat (10) tick();
      sig = 1'b0;
      repeat (92) tick();
      check("timeout_before", longint'(timeout), 0);
      check("locked_before_timeout", longint'(locked), 1);
      tick();
      check("timeout_at_limit", longint'(timeout), 1);
      check("locked_after_timeout", longint'(locked), 0);

      // Resume with jittered periods 20,21,20,19,20,23.
      seg(10, 10, 1'b0, 1'b0);
      check("timeout_holds", longint'(timeout), 1);
      seg(11, 10, 1'b0, 1'b1);
      check("timeout_cleared", longint'(timeout), 0);
      seg(10, 10, 1'b0, 1'b1);
      seg(10,  9, 1'b0, 1'b1);
      seg(10, 10, 1'b1, 1'b1);
      seg(12, 11, 1'b0, 1'b1);

      // Re-lock at 20 after the outlier.
      for (int i = 1; i <= 5; i++) seg(10, 10, i >= 5, 1'b1);

      // Reset mid-period while locked.
      sig = 1'b1;
      repeat (5) tick();
      check("locked_before_rst", longint'(locked), 1);
      #1;
      rst = 1'b1;
      sig = 1'b0;
      #1;
      check("async_rst_period",  longint'(period),  0);
      check("async_rst_valid",   longint'(valid),   0);
      check("async_rst_locked",  longint'(locked),  0);
      check("async_rst_timeout", longint'(timeout), 0);
      repeat (3) tick();
      rst = 1'b0;
      repeat (3) tick();

      // Fresh measurement after reset: first report on the 2nd edge.
      for (int i = 1; i <= 5; i++) seg(10, 10, i >= 5, i >= 2);

      // Enable drop for 50 cycles while locked.
      sig = 1'b1;
      repeat (10) tick();
      en  = 1'b0;
      sig = 1'b0;
      repeat (10) tick();
      check("en_low_locked", longint'(locked), 0);
      check("en_low_period", longint'(period), 20);
      pulse(10, 10);
      pulse(10, 10);
      check("en_low_locked_end",  longint'(locked),  0);
      check("en_low_period_end",  longint'(period),  20);
      check("en_low_timeout_end", longint'(timeout), 0);
      en = 1'b1;
      seg(10, 10, 1'b0, 1'b0);
      seg(10, 10, 1'b0, 1'b1);

      // Minimum period: input toggles every cycle.
      for (int i = 1; i <= 8; i++) seg(1, 1, i >= 5, 1'b1);
      pulse(1, 1);
      repeat (10) tick();

      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period of a slow, periodic input signal in cycles of the system clock, such as a divided clock produced elsewhere in the design. It reports each measured period with a one-cycle valid strobe. It also flags a stable, locked frequency and signals a timeout when edges stop arriving. The block sits on the consumer side of the clock-divider path, in self-check logic, and in frequency-indicator logic driving display or LED modules.

## Interface
- `WIDTH`, default 16: width of the period counter and of `o_PERIOD`.
- `TIMEOUT`, default 65535: cycle count with no rising edge after which a timeout is declared. Range 2 … 2^WIDTH-1.
- `LOCK_COUNT`, default 4: number of consecutive matching periods required for lock. Range ≥1.
- `TOL`, default 0: maximum |new − previous| period difference counted as a match.
- `i_CLK`, in, 1: system clock; all logic on its rising edge.
- `i_RST`, in, 1: reset, asynchronous and active-high.
- `i_EN`, in, 1: measurement enable; low forces IDLE.
- `i_SIG`, in, 1: measured signal, asynchronous to `i_CLK`.
- `o_PERIOD`, out, WIDTH: last measured period in `i_CLK` cycles.
- `o_VALID`, out, 1: one-cycle strobe when `o_PERIOD` updates.
- `o_LOCKED`, out, 1: high while the last LOCK_COUNT comparisons all matched.
- `o_TIMEOUT`, out, 1: sticky flag; no edge seen within TIMEOUT cycles.

## Operation
- **Input conditioning.** `i_SIG` passes through a 2-flop synchronizer `s1`→`s2`, then a history flop `p`.
  - A rising event `rise = s2 & ~p`.
  - All three flops reset to 0.
- **States.** IDLE and MEASURE.
  - **IDLE:** the counter is held at 0.
    - On `rise` with `i_EN`=1: go to MEASURE and set the counter to 1.
    - No `o_VALID` is produced for this first edge.
  - **MEASURE:** the counter increments by 1 each cycle.
    - **On `rise`:** `o_PERIOD` ← counter and `o_VALID` pulses. The counter is set back to 1. The lock logic updates, and `o_TIMEOUT` clears.
    - **On counter == TIMEOUT with no `rise` in the same cycle:** go to IDLE. Set `o_TIMEOUT`=1, clear `o_LOCKED`, clear the match count, and invalidate the previous period.
    - `rise` has priority over timeout when both occur in the same cycle.
  - **`i_EN`=0 in any state:** go to IDLE. Clear the counter, match count and `o_LOCKED`. `o_PERIOD` and `o_TIMEOUT` hold.
- **Lock logic.** Updates on each `o_VALID`.
  - The first period after entering MEASURE has no previous value, so the match count is 0.
  - Later periods within TOL of the previous period increment the match count, saturating at LOCK_COUNT. Any other period resets it to 0.
  - `o_LOCKED` = (match count == LOCK_COUNT).
  - The previous period ← the new period on every `o_VALID`.
- **Arithmetic.**
  - The difference is computed as an absolute value in WIDTH+1 bits, so no wrap occurs.
  - The counter never exceeds TIMEOUT, so it never wraps.
- **Minimum measurable period:** 2 cycles (high ≥1 and low ≥1 cycle after synchronization). Faster inputs alias; no detection is required.

## Timing
- **Reset values:** `o_PERIOD`=0, `o_VALID`=0, `o_LOCKED`=0, `o_TIMEOUT`=0, state IDLE, counter 0.
- **Reset mid-measurement:** immediate return to reset values. The next measurement needs two fresh rising edges.
- **Edge latency:** the first clock edge sampling `i_SIG`=1 is edge k. `s2`=1 at k+1, and the `rise` actions register at edge k+2. `o_VALID` is high during cycle k+2 … k+3.
- **Reported period:** for a steady input of period P cycles (P ≥ 2), `o_PERIOD`=P exactly.
- **Strobe spacing:** `o_VALID` pulses every P cycles.
- **Timeout timing:** `o_TIMEOUT` rises TIMEOUT cycles after the last registered `rise` (counter=1 → TIMEOUT).
- **Lock timing:** `o_LOCKED` rises on the same edge as the (LOCK_COUNT+1)-th `o_VALID` of a stable run. It falls on the same edge as the first mismatching `o_VALID`.

## Test plan
- **Steady lock.** Defaults; `i_SIG` square wave period 20 (10 high / 10 low), `i_EN`=1.
  - Every `o_VALID` has `o_PERIOD`=20, with pulses exactly 20 cycles apart.
  - `o_LOCKED`=1 on the 5th `o_VALID`.
  - No `o_VALID` on the first edge.
- **Timeout.** TIMEOUT=100, period 20 wave, then `i_SIG` held low.
  - `o_TIMEOUT`=1 exactly 100 cycles after the last `rise` registered, with `o_LOCKED`=0.
  - On edges resuming, `o_TIMEOUT` holds until the first `o_VALID`, then clears.
- **Jitter tolerance.** TOL=1; periods 20, 21, 20, 19, 20, 23.
  - Matches accumulate so that `o_LOCKED`=1 after the 5th period.
  - The 23 drops `o_LOCKED` on its `o_VALID`.
- **Minimum period.** `i_SIG` toggling every cycle (period 2).
  - `o_PERIOD`=2 on every `o_VALID`, with strobes every 2 cycles.
- **Reset mid-operation.** `i_RST` pulsed mid-period while locked.
  - All outputs return to 0 asynchronously.
  - The first `o_VALID` after reset occurs on the 2nd post-reset edge, with the correct P.
- **Enable drop.** `i_EN` low for 50 cycles while locked.
  - `o_LOCKED`=0 with no `o_VALID`, and `o_PERIOD` holds its value.
  - After `i_EN`=1 again, the first edge is consumed silently.
